data_mem_stage: RTL and testbench
=================================

# data_mem_stage

Load/store stage placed directly downstream of the ALU. It consumes the ALU's effective address (`ALU_result`), the store operand (`rt_value`) and the opcode, and performs byte, halfword and word accesses to a local synchronous data RAM. It also implements the LL/SC link reservation and returns load or SC data toward writeback through a valid/ready handshake. At most one access is in flight at a time.

## Interface
- `DEPTH_WORDS`, default 256: RAM depth in 32-bit words; must be a power of two.
- `IDX_W`, default $clog2(DEPTH_WORDS): word-index width; derived, not overridden.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  access request.
- `req_ready`  out  1  stage can accept a request.
- `opcode`  in  6  MIPS opcode. Supported: LW 0x23, LBU 0x24, LHU 0x25, LL 0x30, SB 0x28, SH 0x29, SW 0x2b, SC 0x38.
- `addr`  in  32  byte address from the ALU.
- `store_data`  in  32  rt value.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  32  load result, or SC status.
- `rsp_wen`  out  1  `rsp_data` must be written to the register file.
- `misalign`  out  1  completed access was misaligned.
- `link_valid`  out  1  LL reservation held.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
  - IDLE → ACCESS on `req_valid && req_ready`. `req_ready` is 1 only in IDLE.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE unconditionally.
- **Input capture:** `opcode`, `addr` and `store_data` are registered at acceptance. Upstream may change them afterwards.
- **Addressing:** word index = `addr[IDX_W+1:2]`. Upper address bits are ignored, so the RAM wraps. Byte lanes are little-endian: byte 0 = bits 7:0.
- **Alignment:**
  - Word ops (LW, SW, LL, SC) need `addr[1:0]==0`.
  - Halfword ops (SH, LHU) need `addr[0]==0`.
  - A misaligned access does no RAM write and no link change. It responds with `misalign=1`, `rsp_wen=0`, `rsp_data=0`.
- **Loads:**
  - LBU zero-extends the selected byte.
  - LHU zero-extends the selected halfword.
  - LW and LL return the full word.
  - All loads drive `rsp_wen=1`.
- **Stores:**
  - SB and SH write only the addressed byte or halfword lanes, taken from the low bits of `store_data`. SW writes all four lanes.
  - Stores drive `rsp_wen=0` and `rsp_data=0`.
- **LL:** sets `link_valid=1` and records the word index.
- **SC:**
  - Succeeds iff `link_valid` is set and the recorded index equals the current index. On success it writes the word and returns `rsp_data=1`; on failure there is no write and `rsp_data=0`.
  - `rsp_wen=1` in both cases.
  - Every SC clears the link.
- **Link clearing by stores:** SB, SH or SW to the linked word index clear the link.
- **Unsupported opcode:** no RAM or link effect. Responds with `rsp_wen=0`, `rsp_data=0`, `misalign=0`.
- **RAM:** contents are not reset. The RAM keeps its contents through `rst_n`.

## Timing
- **Latency:** `rsp_valid` is high exactly 2 cycles after the accept edge, for exactly 1 cycle. Throughput is one access per 3 cycles.
- **RAM read:** synchronous, registered at the IDLE→ACCESS edge.
- **Writes:** RAM write and link update occur at the ACCESS→RESP edge.
- **Response outputs:** `rsp_data`, `rsp_wen` and `misalign` are registered. They are valid only while `rsp_valid=1` and are held at 0 otherwise.
- **Reset values:** state=IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_data=0`, `rsp_wen=0`, `misalign=0`, `link_valid=0`, link index=0.
- **Reset mid-operation:** `rst_n` low forces the reset values immediately.
  - A store not yet past its ACCESS→RESP edge is dropped.
  - A response pulse in progress is cut off.
- **No back-pressure on the response:** downstream must accept `rsp_valid` in the cycle it is asserted.

## Structure
- **Shared package `mips_defs_pkg`:** opcode constants (OP_LW, OP_LBU, OP_LHU, OP_LL, OP_SB, OP_SH, OP_SW, OP_SC) and the state enum `mem_state_t`. Shared with the ALU and decode.
- **Sub-module `mem_lane_align` (combinational):**
  - Store side: produces the 4-bit byte-enable and the lane-shifted write data from opcode, `addr[1:0]` and `store_data`.
  - Load side: extracts and zero-extends the read data.
  - Also flags misalignment.
- **Top level:** FSM, input registers, RAM array, link registers, response registers.

## Test plan
- **Reset:** assert `rst_n=0` → `req_ready=1`, `rsp_valid=0`, `link_valid=0`, all response outputs 0.
- **Word round-trip:** SW 0xDEADBEEF @0x10, then LW @0x10 → `rsp_data=0xDEADBEEF`, `rsp_wen=1`, `rsp_valid` exactly 2 cycles after accept, `req_ready` low for 2 cycles.
- **Sub-word lanes:** after the above, SB 0x000000AA @0x13 →
  - LW @0x10 = 0xAAADBEEF
  - LBU @0x13 = 0x000000AA
  - LHU @0x12 = 0x0000AAAD
- **LL/SC:**
  - LL @0x20, then SC 5 @0x20 → `rsp_data=1` and the word reads 5. A second SC 7 @0x20 → `rsp_data=0` and the word is still 5.
  - LL @0x20, SW @0x20, SC → 0.
  - LL @0x20, SC @0x24 → 0.
- **Misalignment:** LW @0x11, then SH 0xFFFF @0x13 → both give `misalign=1`, `rsp_wen=0`, `rsp_data=0`, RAM unchanged, link state unchanged.
- **Reset during store:** SW 0x12345678 @0x40 over an old value of 0; pull `rst_n` low during ACCESS → `rsp_valid` never asserts and a subsequent LW @0x40 returns 0. Address wrap: LW @(0x40 + 4·DEPTH_WORDS) reads word 0x40.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg: opcodes and load/store stage state shared by ALU, decode and memory stage
package mips_defs_pkg;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SC  = 6'h38;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store shifting, load extraction and alignment check
module mem_lane_align
  import mips_defs_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        mis
);
  logic word_op, half_op;
  assign word_op = op == OP_LW || op == OP_LL || op == OP_SW || op == OP_SC;
  assign half_op = op == OP_LHU || op == OP_SH;
  assign mis = word_op ? |lo : half_op ? lo[0] : 1'b0;
  assign be = op == OP_SB ? 4'b0001 << lo :
              op == OP_SH ? (lo[1] ? 4'b1100 : 4'b0011) :
              (op == OP_SW || op == OP_SC) ? 4'b1111 : 4'b0000;
  // replicate sub-word data across lanes so the byte enables pick the right copy
  assign wdata = op == OP_SB ? {4{store_data[7:0]}} :
                 op == OP_SH ? {2{store_data[15:0]}} : store_data;
  assign ldata = op == OP_LBU ? {24'b0, rd_data[{lo, 3'b000} +: 8]} :
                 op == OP_LHU ? {16'b0, rd_data[{lo[1], 4'b0000} +: 16]} : rd_data;
endmodule

// File: rtl/data_mem_stage.sv
// data_mem_stage: load/store stage with local synchronous RAM and LL/SC link reservation
module data_mem_stage
  import mips_defs_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_wen,
  output logic        misalign,
  output logic        link_valid
);
  mem_state_t state, nxt;
  logic [5:0] op_q;
  logic [1:0] lo_q;
  logic [IDX_W-1:0] idx_q, link_idx;
  logic [31:0] sd_q, rd_q, wdata, ldata;
  logic [3:0] be;
  logic mis, acc, is_load, is_sc, is_st, sc_ok, we;
  logic [31:0] ram [DEPTH_WORDS];
  logic unused_addr;
  assign unused_addr = ^addr[31:IDX_W+2];
  assign req_ready = state == IDLE;
  assign acc = state == ACCESS;
  assign is_load = op_q == OP_LW || op_q == OP_LBU || op_q == OP_LHU || op_q == OP_LL;
  assign is_st = op_q == OP_SB || op_q == OP_SH || op_q == OP_SW;
  assign is_sc = op_q == OP_SC;
  assign sc_ok = is_sc && link_valid && link_idx == idx_q;
  assign we = acc && !mis && (is_st || sc_ok);
  mem_lane_align u_align (
    .op(op_q), .lo(lo_q), .store_data(sd_q), .rd_data(rd_q),
    .be(be), .wdata(wdata), .ldata(ldata), .mis(mis)
  );
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = req_valid ? ACCESS : IDLE;
      ACCESS:  nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // RAM and captured request are deliberately outside reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_q <= opcode;
      lo_q <= addr[1:0];
      idx_q <= addr[IDX_W+1:2];
      sd_q <= store_data;
      rd_q <= ram[addr[IDX_W+1:2]];
    end
    for (int i = 0; i < 4; i++)
      if (we && be[i]) ram[idx_q][8*i +: 8] <= wdata[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_wen <= 1'b0;
      misalign <= 1'b0;
      link_valid <= 1'b0;
      link_idx <= '0;
    end else begin
      rsp_valid <= acc;
      rsp_wen <= acc && !mis && (is_load || is_sc);
      misalign <= acc && mis;
      rsp_data <= (!acc || mis) ? '0 : is_load ? ldata : {31'b0, sc_ok};
      if (acc && !mis && op_q == OP_LL) begin
        link_valid <= 1'b1;
        link_idx <= idx_q;
      end else if (acc && !mis && (is_sc || (is_st && idx_q == link_idx))) link_valid <= 1'b0;
    end
endmodule

// File: tb/tb_data_mem_stage.sv
// tb_data_mem_stage: randomized and directed checks against a byte-array reference model
module tb_data_mem_stage;
  import mips_defs_pkg::*;
  localparam int DEPTH = 256;
  logic clk = 0, rst_n = 0, req_valid = 0;
  logic [5:0] opcode = 0;
  logic [31:0] addr = 0, store_data = 0;
  logic req_ready, rsp_valid, rsp_wen, misalign, link_valid;
  logic [31:0] rsp_data;
  int total = 0, bad = 0;
  logic [7:0] mb [4*DEPTH];
  logic link_m = 0;
  int lidx_m = 0;
  logic [31:0] exp_d, od;
  logic exp_w, exp_m, ow, om;
  int lat, pulses, rdy_lo;

  always #5 clk = ~clk;

  data_mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .addr(addr), .store_data(store_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_wen(rsp_wen), .misalign(misalign), .link_valid(link_valid)
  );

  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    int b, sz;
    logic [31:0] v;
    b = int'(a & 32'(4*DEPTH-1));
    sz = (op == OP_LW || op == OP_LL || op == OP_SW || op == OP_SC) ? 4 :
         (op == OP_LHU || op == OP_SH) ? 2 : (op == OP_LBU || op == OP_SB) ? 1 : 0;
    exp_d = 0; exp_w = 0; exp_m = 0;
    if (sz == 0) return;
    if (b % sz != 0) begin exp_m = 1; return; end
    if (op == OP_LW || op == OP_LL || op == OP_LHU || op == OP_LBU) begin
      v = 0;
      for (int k = 0; k < sz; k++) v[8*k +: 8] = mb[b+k];
      exp_d = v; exp_w = 1;
      if (op == OP_LL) begin link_m = 1; lidx_m = b / 4; end
    end else if (op == OP_SC) begin
      exp_w = 1;
      if (link_m && lidx_m == b / 4) begin
        for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
        exp_d = 1;
      end
      link_m = 0;
    end else begin
      for (int k = 0; k < sz; k++) mb[b+k] = d[8*k +: 8];
      if (lidx_m == b / 4) link_m = 0;
    end
  endtask

  task automatic xfer(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    opcode = op; addr = a; store_data = d; req_valid = 1;
    @(posedge clk);
    #1;
    req_valid = 0; opcode = 6'($urandom); addr = $urandom; store_data = $urandom;
    od = 0; ow = 0; om = 0; lat = 0; pulses = 0; rdy_lo = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!req_ready) rdy_lo++;
      if (rsp_valid) begin
        pulses++;
        if (lat == 0) begin lat = i; od = rsp_data; ow = rsp_wen; om = misalign; end
      end
    end
    model(op, a, d);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 0;
    #1;
    link_m = 0;
    total += 6;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset req_ready got=%b want=1", req_ready); end
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset rsp_valid got=%b want=0", rsp_valid); end
    if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset rsp_data got=%h want=0", rsp_data); end
    if (rsp_wen !== 1'b0) begin bad++; $display("FAIL reset rsp_wen got=%b want=0", rsp_wen); end
    if (misalign !== 1'b0) begin bad++; $display("FAIL reset misalign got=%b want=0", misalign); end
    if (link_valid !== 1'b0) begin bad++; $display("FAIL reset link_valid got=%b want=0", link_valid); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fill;
    for (int i = 0; i < DEPTH; i++) xfer(OP_SW, 32'(4*i), 32'h0);
  endtask

  task automatic test_word_roundtrip;
    xfer(OP_SW, 32'h10, 32'hDEADBEEF);
    total++;
    if (od !== 0 || ow !== 0 || om !== 0 || lat != 2 || pulses != 1 || rdy_lo != 2) begin
      bad++; $display("FAIL sw_rsp got d=%h w=%b m=%b lat=%0d pulses=%0d rdy_lo=%0d want 0 0 0 2 1 2", od, ow, om, lat, pulses, rdy_lo);
    end
    xfer(OP_LW, 32'h10, 32'h0);
    total++;
    if (od !== 32'hDEADBEEF || ow !== 1'b1 || om !== 0 || lat != 2 || pulses != 1 || rdy_lo != 2) begin
      bad++; $display("FAIL lw_rsp got d=%h w=%b m=%b lat=%0d pulses=%0d rdy_lo=%0d want deadbeef 1 0 2 1 2", od, ow, om, lat, pulses, rdy_lo);
    end
  endtask

  task automatic test_subword;
    logic [5:0] ops [4] = '{OP_SB, OP_LW, OP_LBU, OP_LHU};
    logic [31:0] as [4] = '{32'h13, 32'h10, 32'h13, 32'h12};
    logic [31:0] want [4] = '{32'h0, 32'hAAADBEEF, 32'h000000AA, 32'h0000AAAD};
    for (int i = 0; i < 4; i++) begin
      xfer(ops[i], as[i], 32'h5555_55AA);
      total++;
      if (od !== want[i] || ow !== exp_w || om !== 0) begin
        bad++; $display("FAIL subword op=%h a=%h got d=%h w=%b m=%b want d=%h w=%b m=0", ops[i], as[i], od, ow, om, want[i], exp_w);
      end
    end
  endtask

  task automatic test_llsc;
    logic [5:0] ops [13] = '{OP_LL, OP_SC, OP_LW, OP_SC, OP_LW, OP_LL, OP_SW, OP_SC, OP_LW, OP_LL, OP_SC, OP_LW, OP_LW};
    logic [31:0] as [13] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h24, 32'h24, 32'h20};
    logic [31:0] ds [13] = '{0, 5, 0, 7, 0, 0, 9, 3, 0, 0, 6, 0, 0};
    for (int i = 0; i < 13; i++) begin
      xfer(ops[i], as[i], ds[i]);
      total++;
      if (od !== exp_d || ow !== exp_w || om !== exp_m || lat != 2 || pulses != 1) begin
        bad++; $display("FAIL llsc step=%0d got d=%h w=%b m=%b lat=%0d want d=%h w=%b m=%b lat=2", i, od, ow, om, lat, exp_d, exp_w, exp_m);
      end
      total++;
      if (link_valid !== link_m) begin bad++; $display("FAIL llsc_link step=%0d got=%b want=%b", i, link_valid, link_m); end
    end
  endtask

  task automatic test_misalign;
    logic [5:0] ops [6] = '{OP_LL, OP_LW, OP_SH, OP_SC, OP_LHU, OP_LW};
    logic [31:0] as [6] = '{32'h10, 32'h11, 32'h13, 32'h12, 32'h11, 32'h10};
    logic [31:0] ds [6] = '{0, 0, 32'hFFFF, 32'h1234, 0, 0};
    for (int i = 0; i < 6; i++) begin
      xfer(ops[i], as[i], ds[i]);
      total++;
      if (od !== exp_d || ow !== exp_w || om !== exp_m) begin
        bad++; $display("FAIL misalign step=%0d got d=%h w=%b m=%b want d=%h w=%b m=%b", i, od, ow, om, exp_d, exp_w, exp_m);
      end
      total++;
      if (link_valid !== link_m) begin bad++; $display("FAIL misalign_link step=%0d got=%b want=%b", i, link_valid, link_m); end
    end
  endtask

  task automatic test_unsupported;
    logic [5:0] ops [4] = '{6'h00, 6'h20, 6'h2a, OP_LW};
    for (int i = 0; i < 4; i++) begin
      xfer(ops[i], 32'h10, 32'hFFFF_FFFF);
      total++;
      if (od !== exp_d || ow !== exp_w || om !== exp_m || pulses != 1 || link_valid !== link_m) begin
        bad++; $display("FAIL unsupported op=%h got d=%h w=%b m=%b p=%0d lv=%b want d=%h w=%b m=%b p=1 lv=%b", ops[i], od, ow, om, pulses, link_valid, exp_d, exp_w, exp_m, link_m);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    model(OP_LW, 32'h10, 0);
    n = 0;
    @(negedge clk);
    opcode = OP_LW; addr = 32'h10; req_valid = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n++;
        total++;
        if (i % 3 != 2 || rsp_data !== exp_d) begin
          bad++; $display("FAIL b2b pulse at=%0d d=%h want at%%3=2 d=%h", i, rsp_data, exp_d);
        end
      end
    end
    req_valid = 0;
    total++;
    if (n != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", n); end
  endtask

  task automatic test_reset_mid;
    int n;
    model(OP_LW, 32'h10, 0);
    @(negedge clk);
    opcode = OP_LW; addr = 32'h10; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin bad++; $display("FAIL cut_pre got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, exp_d); end
    #1 rst_n = 0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin bad++; $display("FAIL cut_post got v=%b d=%h want v=0 d=0", rsp_valid, rsp_data); end
    @(negedge clk);
    rst_n = 1;
    link_m = 0;
    xfer(OP_LL, 32'h80, 0);
    total++;
    if (link_valid !== 1'b1) begin bad++; $display("FAIL drop_link_pre got=%b want=1", link_valid); end
    @(negedge clk);
    opcode = OP_SW; addr = 32'h40; store_data = 32'h12345678; req_valid = 1;
    @(posedge clk);
    #1 req_valid = 0;
    rst_n = 0;
    #1;
    link_m = 0;
    total++;
    if (link_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL drop_state got lv=%b rdy=%b v=%b want 0 1 0", link_valid, req_ready, rsp_valid);
    end
    n = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid) n++; end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (rsp_valid) n++; end
    total++;
    if (n != 0) begin bad++; $display("FAIL drop_pulse got=%0d want=0", n); end
    xfer(OP_LW, 32'h40 + 32'(4*DEPTH), 0);
    total++;
    if (od !== 32'h0 || od !== exp_d || ow !== 1'b1) begin bad++; $display("FAIL drop_wrap got d=%h w=%b want d=0 w=1", od, ow); end
  endtask

  task automatic test_random;
    logic [5:0] tbl [10] = '{OP_LW, OP_LBU, OP_LHU, OP_LL, OP_SB, OP_SH, OP_SW, OP_SC, 6'h00, 6'h20};
    logic [5:0] op;
    logic [31:0] a, d;
    for (int i = 0; i < 200; i++) begin
      op = tbl[$urandom_range(0, 9)];
      a = ($urandom & ~32'h3FF) | 32'($urandom_range(0, 63));
      d = $urandom;
      xfer(op, a, d);
      total++;
      if (od !== exp_d || ow !== exp_w || om !== exp_m || lat != 2 || pulses != 1 || link_valid !== link_m) begin
        bad++; $display("FAIL random op=%h a=%h got d=%h w=%b m=%b lat=%0d lv=%b want d=%h w=%b m=%b lat=2 lv=%b", op, a, od, ow, om, lat, link_valid, exp_d, exp_w, exp_m, link_m);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_word_roundtrip;
    test_subword;
    test_llsc;
    test_misalign;
    test_unsupported;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
